// File: rtl/fadd_ctrl_pkg.sv
// Shared types and constants for the floating-point adder sequencer.
// Holds the FSM state encoding, mantissa/LZ widths and the default normalise step.
package fadd_ctrl_pkg;

   localparam int MANT_W        = 48;
   localparam int LZ_W          = 6;
   localparam int NORM_STEP_DEF = 8;

   typedef enum logic [2:0] {
      IDLE,
      ALIGN,
      ADDSUB,
      NORM,
      ROUND,
      POSTNORM,
      DONE
   } state_t;

   function automatic logic [LZ_W-1:0] min_lz(input logic [LZ_W-1:0] a,
                                              input logic [LZ_W-1:0] b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/fadd_norm_cnt.sv
// Remaining-left-shift counter for multi-cycle normalisation: loads the leading-zero
// count, then each step removes min(rem, NORM_STEP); last flags the final step.
module fadd_norm_cnt
   import fadd_ctrl_pkg::*;
#(
   parameter int NORM_STEP = NORM_STEP_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load,
   input  logic [LZ_W-1:0] load_val,
   input  logic            step,
   output logic [LZ_W-1:0] remaining,
   output logic [LZ_W-1:0] shamt,
   output logic            last
);

   localparam logic [LZ_W-1:0] STEP_V = LZ_W'(NORM_STEP);

   logic [LZ_W-1:0] rem_q;
   logic [LZ_W-1:0] rem_d;

   always_comb begin
      shamt = min_lz(rem_q, STEP_V);
      last  = (rem_q <= STEP_V);
      rem_d = rem_q;
      if (load) begin
         rem_d = load_val;
      end else if (step) begin
         rem_d = rem_q - shamt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rem_q <= '0;
      end else begin
         rem_q <= rem_d;
      end
   end

   assign remaining = rem_q;

endmodule

// File: rtl/fadd_seq_ctrl.sv
// Floating-point add sequencer: ALIGN, ADDSUB, NORM (multi-cycle), ROUND, POSTNORM, DONE.
// Result waits in DONE until res_ready; flush kills any op. FADD_SPECIAL_BYPASS_EN enables ALIGN->DONE.
module fadd_seq_ctrl
   import fadd_ctrl_pkg::*;
#(
   parameter int NORM_STEP = NORM_STEP_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [LZ_W-1:0] lz_count,
   input  logic            carry,
   input  logic            round_carry,
   input  logic            special_case,
   input  logic            flush,
   output logic            busy,
   output logic            align_en,
   output logic            addsub_en,
   output logic            norm_en,
   output logic            norm_rshift,
   output logic            round_en,
   output logic [LZ_W-1:0] norm_shamt,
   output logic            sel_special,
   output logic            res_valid,
   input  logic            res_ready
);

   state_t          state_q;
   state_t          state_d;
   logic            carry_q;
   logic            carry_d;
   logic            cnt_load;
   logic            cnt_step;
   logic [LZ_W-1:0] cnt_shamt;
   logic            cnt_last;
   logic [LZ_W-1:0] rem_unused;

   fadd_norm_cnt #(
      .NORM_STEP (NORM_STEP)
   ) u_norm_cnt (
      .clk       (clk),
      .reset     (reset),
      .load      (cnt_load),
      .load_val  (lz_count),
      .step      (cnt_step),
      .remaining (rem_unused),
      .shamt     (cnt_shamt),
      .last      (cnt_last)
   );

`ifdef FADD_SPECIAL_BYPASS_EN
   logic sel_q;
   logic sel_d;
`else
   logic special_unused;
   assign special_unused = special_case;
`endif

   always_comb begin
      state_d     = state_q;
      carry_d     = carry_q;
      cnt_load    = 1'b0;
      cnt_step    = 1'b0;
      req_ready   = 1'b0;
      align_en    = 1'b0;
      addsub_en   = 1'b0;
      norm_en     = 1'b0;
      norm_rshift = 1'b0;
      round_en    = 1'b0;
      norm_shamt  = '0;
      res_valid   = 1'b0;
`ifdef FADD_SPECIAL_BYPASS_EN
      sel_d       = sel_q;
`endif
      case (state_q)
         IDLE: begin
            req_ready = !flush;
            if (req_valid && !flush) state_d = ALIGN;
         end
         ALIGN: begin
            align_en = 1'b1;
            state_d  = ADDSUB;
`ifdef FADD_SPECIAL_BYPASS_EN
            if (special_case) begin
               state_d = DONE;
               sel_d   = 1'b1;
            end
`endif
         end
         ADDSUB: begin
            addsub_en = 1'b1;
            cnt_load  = 1'b1;
            carry_d   = carry;
            // Carry-out needs a single right shift regardless of the LZ count.
            if (carry) begin
               state_d = NORM;
            end else if ((lz_count == '0) || (lz_count >= LZ_W'(MANT_W))) begin
               state_d = ROUND;
            end else begin
               state_d = NORM;
            end
         end
         NORM: begin
            norm_en = 1'b1;
            if (carry_q) begin
               norm_rshift = 1'b1;
               state_d     = ROUND;
            end else begin
               norm_shamt = cnt_shamt;
               cnt_step   = 1'b1;
               if (cnt_last) state_d = ROUND;
            end
         end
         ROUND: begin
            round_en = 1'b1;
            state_d  = round_carry ? POSTNORM : DONE;
         end
         POSTNORM: begin
            norm_en     = 1'b1;
            norm_rshift = 1'b1;
            state_d     = DONE;
         end
         DONE: begin
            res_valid = !flush;
            if (res_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (flush) state_d = IDLE;
`ifdef FADD_SPECIAL_BYPASS_EN
      if (state_d == IDLE) sel_d = 1'b0;
`endif
   end

   assign busy = (state_q != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         carry_q <= carry_d;
      end
   end

`ifdef FADD_SPECIAL_BYPASS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         sel_q <= 1'b0;
      end else begin
         sel_q <= sel_d;
      end
   end
   assign sel_special = sel_q;
`else
   assign sel_special = 1'b0;
`endif

endmodule

// File: tb/tb_fadd_seq_ctrl.sv
// Directed bench for fadd_seq_ctrl: a per-cycle output model is queued per operation
// and popped against the DUT each cycle, plus result-latency checks.
module tb_fadd_seq_ctrl;

   localparam int STEP = 8;

   logic       clk          = 1'b0;
   logic       reset        = 1'b1;
   logic       req_valid    = 1'b0;
   logic [5:0] lz_count     = '0;
   logic       carry        = 1'b0;
   logic       round_carry  = 1'b0;
   logic       special_case = 1'b0;
   logic       flush        = 1'b0;
   logic       res_ready    = 1'b0;

   logic       req_ready;
   logic       busy;
   logic       align_en;
   logic       addsub_en;
   logic       norm_en;
   logic       norm_rshift;
   logic       round_en;
   logic [5:0] norm_shamt;
   logic       sel_special;
   logic       res_valid;

   int checks   = 0;
   int failures = 0;

   logic [14:0] exp_q[$];
   logic [14:0] obs;

   fadd_seq_ctrl #(
      .NORM_STEP (STEP)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .lz_count     (lz_count),
      .carry        (carry),
      .round_carry  (round_carry),
      .special_case (special_case),
      .flush        (flush),
      .busy         (busy),
      .align_en     (align_en),
      .addsub_en    (addsub_en),
      .norm_en      (norm_en),
      .norm_rshift  (norm_rshift),
      .round_en     (round_en),
      .norm_shamt   (norm_shamt),
      .sel_special  (sel_special),
      .res_valid    (res_valid),
      .res_ready    (res_ready)
   );

   always #5 clk = ~clk;

   assign obs = {align_en, addsub_en, norm_en, norm_rshift, round_en,
                 res_valid, sel_special, busy, req_ready, norm_shamt};

   function automatic logic [14:0] vec(input logic al, input logic ad, input logic nm,
                                       input logic rs, input logic rd, input logic rv,
                                       input logic sl, input logic bz, input logic rr,
                                       input int sh);
      logic [5:0] s;
      s = sh[5:0];
      return {al, ad, nm, rs, rd, rv, sl, bz, rr, s};
   endfunction

   task automatic check(input string tag, input int got, input int expv);
      checks++;
      assert (got === expv) else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, expv);
      end
   endtask

   // Expected outputs for every cycle after the accepting edge.
   function automatic void build(input int lz, input bit cy, input bit rc, input bit sp,
                                 input int hold, input int abort_at);
      int  r;
      int  s;
      bit  byp;
      exp_q.delete();
      byp = 1'b0;
`ifdef FADD_SPECIAL_BYPASS_EN
      byp = sp;
`endif
      exp_q.push_back(vec(1,0,0,0,0,0,0,1,0,0));
      if (!byp) begin
         exp_q.push_back(vec(0,1,0,0,0,0,0,1,0,0));
         if (cy) begin
            exp_q.push_back(vec(0,0,1,1,0,0,0,1,0,0));
         end else if (lz != 0 && lz < 48) begin
            r = lz;
            while (r > 0) begin
               s = (r < STEP) ? r : STEP;
               exp_q.push_back(vec(0,0,1,0,0,0,0,1,0,s));
               r -= s;
            end
         end
         exp_q.push_back(vec(0,0,0,0,1,0,0,1,0,0));
         if (rc) exp_q.push_back(vec(0,0,1,1,0,0,0,1,0,0));
      end
      for (int i = 0; i <= hold; i++) exp_q.push_back(vec(0,0,0,0,0,1,byp,1,0,0));
      if (abort_at > 0) begin
         while (exp_q.size() > abort_at) void'(exp_q.pop_back());
         for (int i = 0; i < 3; i++) exp_q.push_back(vec(0,0,0,0,0,0,0,0,1,0));
      end else begin
         exp_q.push_back(vec(0,0,0,0,0,0,0,0,1,0));
      end
   endfunction

   task automatic run_op(input string tag, input int lz, input bit cy, input bit rc,
                         input bit sp, input int hold, input int abort_at,
                         input bit abort_rst, input int exp_lat);
      int          lat;
      int          done_cnt;
      int          n;
      logic [14:0] e;
      lat      = -1;
      done_cnt = 0;
      build(lz, cy, rc, sp, hold, abort_at);
      n = exp_q.size();
      lz_count     = lz[5:0];
      carry        = cy;
      round_carry  = rc;
      special_case = sp;
      req_valid    = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int c = 1; c <= n; c++) begin
         @(negedge clk);
         e = exp_q.pop_front();
         check($sformatf("%s_cyc%0d", tag, c), int'(obs), int'(e));
         if (res_valid) begin
            if (lat < 0) lat = c;
            done_cnt++;
            res_ready = (done_cnt == hold + 1);
         end
         if (c == abort_at) begin
            if (abort_rst) reset = 1'b1;
            else           flush = 1'b1;
         end
         @(posedge clk);
         #1;
         res_ready = 1'b0;
         flush     = 1'b0;
         reset     = 1'b0;
      end
      check({tag, "_lat"}, lat, exp_lat);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("reset_idle", int'(obs), int'(vec(0,0,0,0,0,0,0,0,1,0)));

      // Request with flush in IDLE must not be accepted.
      @(posedge clk);
      #1;
      req_valid = 1'b1;
      flush     = 1'b1;
      @(negedge clk);
      check("flush_blocks_ready", int'(req_ready), 0);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      flush     = 1'b0;
      @(negedge clk);
      check("flush_no_accept", int'(obs), int'(vec(0,0,0,0,0,0,0,0,1,0)));
      @(posedge clk);
      #1;

      run_op("base",       0,  0, 0, 0, 0, 0, 0, 4);
      run_op("lz19",       19, 0, 0, 0, 0, 0, 0, 7);
      run_op("carry_rc",   5,  1, 1, 0, 0, 0, 0, 6);
      run_op("hold5",      0,  0, 0, 0, 5, 0, 0, 4);
      run_op("lz8",        8,  0, 0, 0, 0, 0, 0, 5);
      run_op("lz9",        9,  0, 0, 0, 0, 0, 0, 6);
      run_op("lz47",       47, 0, 0, 0, 0, 0, 0, 10);
      run_op("lz48",       48, 0, 0, 0, 0, 0, 0, 4);
      run_op("lz63",       63, 0, 0, 0, 0, 0, 0, 4);
      run_op("rc_only",    0,  0, 1, 0, 0, 0, 0, 5);
      run_op("flush_norm", 40, 0, 0, 0, 0, 4, 0, -1);
      run_op("post_flush", 19, 0, 0, 0, 0, 0, 0, 7);
      run_op("rst_norm",   40, 0, 0, 0, 0, 4, 1, -1);
      run_op("post_rst",   3,  0, 1, 0, 0, 0, 0, 6);
`ifdef FADD_SPECIAL_BYPASS_EN
      run_op("special",      0, 0, 0, 1, 0, 0, 0, 2);
      run_op("special_hold", 0, 0, 0, 1, 2, 0, 0, 2);
`else
      run_op("special",      0, 0, 0, 1, 0, 0, 0, 4);
      run_op("special_hold", 0, 0, 0, 1, 2, 0, 0, 4);
`endif
      special_case = 1'b0;
      run_op("after_special", 0, 0, 0, 0, 0, 0, 0, 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
